// File: rtl/mem_commutator.sv
// Round-robin bus commutator: instruction/data masters to boot ROM / RAM slaves.
// Latency: slave strobe one cycle after grant; master ack one cycle after slave ack (min 2).
// Backpressure: one transaction in flight; masters hold stb until ack, missing slave ack times out.
module mem_commutator #(
  parameter logic [13:0] ROM_BASE_HI = 14'h0000,
  parameter logic [13:0] RAM_BASE_HI = 14'h0001,
  parameter int          TIMEOUT     = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_stb_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic [31:0] i_data_o,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_data_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] d_data_o,
  output logic        rom_stb_o,
  output logic [15:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic        ram_stb_o,
  output logic        ram_we_o,
  output logic [15:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      r_state;
  logic        r_last_d;   // 1: data master was granted last
  logic        r_gnt_d;    // current grantee is the data master
  logic        r_we;
  logic        r_tgt_ram;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic        w_any;
  logic        w_gnt_d;
  logic [31:0] w_addr;
  logic        w_we;
  logic        w_hit_rom;
  logic        w_hit_ram;
  logic        w_ok;
  logic        w_ack;
  logic        w_unused_lsb;

  // On a tie the master that was not served last wins.
  assign w_any     = i_stb_i | d_stb_i;
  assign w_gnt_d   = d_stb_i & (~i_stb_i | ~r_last_d);
  assign w_addr    = w_gnt_d ? d_addr_i : i_addr_i;
  assign w_we      = w_gnt_d & d_we_i;
  assign w_hit_rom = (w_addr[31:18] == ROM_BASE_HI);
  assign w_hit_ram = (w_addr[31:18] == RAM_BASE_HI);
  // The ROM is read-only, so a ROM write is answered with an error like an unmapped access.
  assign w_ok      = (w_hit_rom & ~w_we) | w_hit_ram;
  assign w_ack     = r_tgt_ram ? ram_ack_i : rom_ack_i;
  assign w_unused_lsb = ^w_addr[1:0];

  // Grant, slave handshake with watchdog, and one-cycle master response.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_we       <= 1'b0;
      r_tgt_ram  <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      i_ack_o    <= 1'b0;
      i_err_o    <= 1'b0;
      i_data_o   <= '0;
      d_ack_o    <= 1'b0;
      d_err_o    <= 1'b0;
      d_data_o   <= '0;
      rom_stb_o  <= 1'b0;
      rom_addr_o <= '0;
      ram_stb_o  <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_sel_o  <= '0;
      ram_data_o <= '0;
    end else begin
      i_ack_o  <= 1'b0;
      i_err_o  <= 1'b0;
      i_data_o <= '0;
      d_ack_o  <= 1'b0;
      d_err_o  <= 1'b0;
      d_data_o <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_d   <= w_gnt_d;
            r_we      <= w_we;
            r_tgt_ram <= w_hit_ram;
            r_cnt     <= '0;
            if (w_ok) begin
              r_state <= REQ;
              if (w_hit_ram) begin
                ram_stb_o  <= 1'b1;
                ram_we_o   <= w_we;
                ram_addr_o <= w_addr[17:2];
                ram_sel_o  <= w_gnt_d ? d_sel_i : 4'hF;
                ram_data_o <= w_gnt_d ? d_data_i : 32'h0;
              end else begin
                rom_stb_o  <= 1'b1;
                rom_addr_o <= w_addr[17:2];
              end
            end else begin
              r_state <= RESP;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        REQ: begin
          if (w_ack) begin
            r_state   <= RESP;
            r_err     <= 1'b0;
            r_rdata   <= r_we ? 32'h0 : (r_tgt_ram ? ram_data_i : rom_data_i);
            rom_stb_o <= 1'b0;
            ram_stb_o <= 1'b0;
            ram_we_o  <= 1'b0;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_state   <= RESP;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            rom_stb_o <= 1'b0;
            ram_stb_o <= 1'b0;
            ram_we_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          if (r_gnt_d) begin
            d_ack_o  <= 1'b1;
            d_err_o  <= r_err;
            d_data_o <= r_rdata;
          end else begin
            i_ack_o  <= 1'b1;
            i_err_o  <= r_err;
            i_data_o <= r_rdata;
          end
          r_last_d <= r_gnt_d;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_commutator.sv
// Directed bench for mem_commutator: reset, ROM/RAM access, arbitration, errors, timeout, stray acks.
// Latency: checks master ack cycle numbers against the request edge.
// Backpressure: slave acks driven manually or by an auto-responder tied to the slave strobe.
module tb_mem_commutator;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        i_stb_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_ack_o, i_err_o;
  logic [31:0] i_data_o;
  logic        d_stb_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [3:0]  d_sel_i = '0;
  logic [31:0] d_data_i = '0;
  logic        d_ack_o, d_err_o;
  logic [31:0] d_data_o;
  logic        rom_stb_o;
  logic [15:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i = '0;
  logic        ram_stb_o, ram_we_o;
  logic [15:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic        ram_ack_i;
  logic [31:0] ram_data_i = '0;

  logic rom_ack_m = 1'b0, ram_ack_m = 1'b0;
  logic rom_auto = 1'b0, ram_auto = 1'b0;
  assign rom_ack_i = rom_ack_m | (rom_auto & rom_stb_o);
  assign ram_ack_i = ram_ack_m | (ram_auto & ram_stb_o);

  int total = 0;
  int bad   = 0;

  mem_commutator #(.ROM_BASE_HI(14'h0000), .RAM_BASE_HI(14'h0001), .TIMEOUT(15)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .i_stb_i(i_stb_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_err_o(i_err_o), .i_data_o(i_data_o),
    .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i), .d_data_i(d_data_i),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o), .d_data_o(d_data_o),
    .rom_stb_o(rom_stb_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i),
    .ram_stb_o(ram_stb_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int acks;
    int stbcnt;
    int ackat;
    logic exp_d;

    // ---------------- reset state
    tick(); tick();
    chk("rst_rom_stb", rom_stb_o, 0);
    chk("rst_ram_stb", ram_stb_o, 0);
    chk("rst_i_ack", i_ack_o, 0);
    chk("rst_d_ack", d_ack_o, 0);
    chk("rst_rom_addr", rom_addr_o, 0);
    chk("rst_ram_we", ram_we_o, 0);
    sys_rst = 1'b0;
    tick();

    // ---------------- ROM read, ack in first REQ cycle
    i_stb_i = 1'b1; i_addr_i = 32'h0000_0010;
    tick();                                   // edge N
    chk("romrd_stb", rom_stb_o, 1);
    chk("romrd_addr", rom_addr_o, 32'h0004);
    chk("romrd_ramstb", ram_stb_o, 0);
    rom_ack_m = 1'b1; rom_data_i = 32'hFFFF_FFFF;
    tick();                                   // N+1
    rom_ack_m = 1'b0;
    chk("romrd_stb_drop", rom_stb_o, 0);
    chk("romrd_noack_n1", i_ack_o, 0);
    tick();                                   // N+2
    chk("romrd_ack", i_ack_o, 1);
    chk("romrd_data", i_data_o, 32'hFFFF_FFFF);
    chk("romrd_err", i_err_o, 0);
    chk("romrd_dack", d_ack_o, 0);
    i_stb_i = 1'b0;
    tick();
    chk("romrd_ack_pulse", i_ack_o, 0);

    // ---------------- RAM write, ack in third REQ cycle
    d_stb_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0004_0008; d_sel_i = 4'b0011; d_data_i = 32'h1234_5678;
    tick();                                   // N
    chk("ramwr_stb", ram_stb_o, 1);
    chk("ramwr_we", ram_we_o, 1);
    chk("ramwr_addr", ram_addr_o, 32'h0002);
    chk("ramwr_sel", ram_sel_o, 32'h3);
    chk("ramwr_data", ram_data_o, 32'h1234_5678);
    chk("ramwr_romstb", rom_stb_o, 0);
    tick();                                   // N+1
    tick();                                   // N+2
    ram_ack_m = 1'b1; ram_data_i = 32'hDEAD_BEEF;
    tick();                                   // N+3
    ram_ack_m = 1'b0;
    chk("ramwr_noack_n3", d_ack_o, 0);
    tick();                                   // N+4
    chk("ramwr_ack", d_ack_o, 1);
    chk("ramwr_err", d_err_o, 0);
    chk("ramwr_rdata0", d_data_o, 0);
    d_stb_i = 1'b0; d_we_i = 1'b0;
    tick();

    // ---------------- reset mid-REQ
    d_stb_i = 1'b1; d_addr_i = 32'h0004_0000;
    tick();
    chk("rstreq_stb", ram_stb_o, 1);
    tick();
    sys_rst = 1'b1;
    #1;
    chk("rstreq_stb_async", ram_stb_o, 0);
    chk("rstreq_dack", d_ack_o, 0);
    tick();
    sys_rst = 1'b0;
    d_stb_i = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (d_ack_o || i_ack_o) acks++;
    end
    chk("rstreq_no_ack", acks, 0);

    // ---------------- arbitration after reset: D, I, D, I
    rom_auto = 1'b1; rom_data_i = 32'hCAFE_0000;
    i_addr_i = 32'h0000_0020; d_addr_i = 32'h0000_0030; d_we_i = 1'b0;
    i_stb_i = 1'b1; d_stb_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      for (int k = 0; k < 10; k++) begin
        tick();
        if (i_ack_o || d_ack_o) break;
      end
      chk($sformatf("arb%0d_dack", t), d_ack_o, exp_d);
      chk($sformatf("arb%0d_iack", t), i_ack_o, !exp_d);
    end
    i_stb_i = 1'b0; d_stb_i = 1'b0;
    tick();
    chk("arb_ack_clear", i_ack_o | d_ack_o, 0);
    rom_auto = 1'b0;
    tick();

    // ---------------- ROM write -> error at N+1
    d_stb_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0000;
    tick();                                   // N
    chk("romwr_nostb", rom_stb_o | ram_stb_o, 0);
    chk("romwr_noack_n", d_ack_o, 0);
    tick();                                   // N+1
    chk("romwr_ack", d_ack_o, 1);
    chk("romwr_err", d_err_o, 1);
    chk("romwr_data", d_data_o, 0);
    d_stb_i = 1'b0; d_we_i = 1'b0;
    tick();

    // ---------------- unmapped read -> error at N+1
    i_stb_i = 1'b1; i_addr_i = 32'h0010_0000;
    tick();
    chk("unmap_nostb", rom_stb_o | ram_stb_o, 0);
    tick();
    chk("unmap_ack", i_ack_o, 1);
    chk("unmap_err", i_err_o, 1);
    i_stb_i = 1'b0;
    tick();

    // ---------------- ROM read timeout
    i_stb_i = 1'b1; i_addr_i = 32'h0000_0040;
    stbcnt = 0; ackat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rom_stb_o) stbcnt++;
      if (i_ack_o) begin
        ackat = k;
        break;
      end
    end
    chk("tmo_stb_cycles", stbcnt, 15);
    chk("tmo_ack_edge", ackat, 17);
    chk("tmo_err", i_err_o, 1);
    chk("tmo_data", i_data_o, 0);
    i_stb_i = 1'b0;
    tick();

    // ---------------- stray RAM acks in IDLE and during ROM REQ
    ram_ack_m = 1'b1;
    tick();
    tick();
    chk("stray_idle_ack", i_ack_o | d_ack_o, 0);
    chk("stray_idle_stb", rom_stb_o | ram_stb_o, 0);
    ram_ack_m = 1'b0;
    i_stb_i = 1'b1; i_addr_i = 32'h0003_FFFC;
    tick();                                   // N
    chk("stray_romaddr", rom_addr_o, 32'hFFFF);
    ram_ack_m = 1'b1;
    tick();                                   // N+1
    ram_ack_m = 1'b0;
    chk("stray_req_stb", rom_stb_o, 1);
    chk("stray_req_noack", i_ack_o, 0);
    rom_ack_m = 1'b1; rom_data_i = 32'h5A5A_0001;
    tick();                                   // N+2
    rom_ack_m = 1'b0;
    tick();                                   // N+3
    chk("stray_ack", i_ack_o, 1);
    chk("stray_data", i_data_o, 32'h5A5A_0001);
    chk("stray_err", i_err_o, 0);
    i_stb_i = 1'b0;
    tick();

    // ---------------- RAM read after all that, auto ack
    ram_auto = 1'b1; ram_data_i = 32'h1357_2468;
    d_stb_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0004_0010; d_sel_i = 4'hF;
    tick();                                   // N
    chk("ramrd_addr", ram_addr_o, 32'h0004);
    tick();                                   // N+1
    tick();                                   // N+2
    chk("ramrd_ack", d_ack_o, 1);
    chk("ramrd_data", d_data_o, 32'h1357_2468);
    d_stb_i = 1'b0; ram_auto = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
